// File: rtl/step_to_note.sv
// step_to_note: inverse pitch lookup. Converts an NCO phase step back to the
// nearest MIDI note by a 7-step successive-approximation search over the
// external step-size table (registered read, one cycle of read latency).
// Optional build macro STEP_TO_NOTE_ROUND_EN adds nearest-note rounding
// (one extra table read of the upper neighbour, ties go to the lower note).
// Without the macro the result is the floor index.
//
// Handshake: start is a request sampled only in IDLE (no backpressure, a
// request while busy or in the done cycle is dropped); busy covers the
// conversion; done is a one-cycle strobe and note/exact/under are valid from
// that strobe until the next one.
module step_to_note (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] step,
   output logic        busy,
   output logic        done,
   output logic [6:0]  note,
   output logic        exact,
   output logic        under,
   output logic        rom_ce,
   output logic [6:0]  rom_a,
   input  logic [15:0] rom_d
);

   typedef enum logic [2:0] {
      IDLE,
      SAR_RD,
      SAR_CMP,
      LO_RD,
      LO_CMP,
`ifdef STEP_TO_NOTE_ROUND_EN
      HI_RD,
      HI_CMP,
`endif
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] s_q, s_d;          // latched step being converted
   logic [6:0]  r_q, r_d;          // result under construction
   logic [2:0]  b_q, b_d;          // bit currently being tried
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [6:0]  note_q, note_d;
   logic        exact_q, exact_d;
   logic        under_q, under_d;
   logic        rom_ce_q, rom_ce_d;
   logic [6:0]  rom_a_q, rom_a_d;
   logic [6:0]  r_new;             // result with the current trial bit resolved
   logic        lo_under;          // step below the floor entry
   logic        lo_exact;          // step equal to the floor entry

`ifdef STEP_TO_NOTE_ROUND_EN
   logic [15:0] tlo_q, tlo_d;      // floor table entry, kept for the distance test
   logic        lo_exact_q, lo_exact_d;
   logic        lo_under_q, lo_under_d;
   logic [15:0] dlo;
   logic [15:0] dhi;
   logic [6:0]  r_fin;
`endif

   assign busy   = busy_q;
   assign done   = done_q;
   assign note   = note_q;
   assign exact  = exact_q;
   assign under  = under_q;
   assign rom_ce = rom_ce_q;
   assign rom_a  = rom_a_q;

   // Next-state and registered-output logic. Table reads are issued on the
   // edge entering a *_RD state so the data arrives in the matching *_CMP state.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      r_d      = r_q;
      b_d      = b_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      note_d   = note_q;
      exact_d  = exact_q;
      under_d  = under_q;
      rom_ce_d = 1'b0;
      rom_a_d  = rom_a_q;
      r_new    = r_q;
      lo_under = (s_q < rom_d);
      lo_exact = (s_q == rom_d);
`ifdef STEP_TO_NOTE_ROUND_EN
      tlo_d      = tlo_q;
      lo_exact_d = lo_exact_q;
      lo_under_d = lo_under_q;
      dlo        = s_q - tlo_q;
      dhi        = rom_d - s_q;
      r_fin      = (dhi < dlo) ? r_q + 7'd1 : r_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               s_d      = step;
               r_d      = 7'd0;
               b_d      = 3'd6;
               busy_d   = 1'b1;
               rom_ce_d = 1'b1;
               rom_a_d  = 7'h40;
               state_d  = SAR_RD;
            end
         end
         SAR_RD: begin
            state_d = SAR_CMP;
         end
         SAR_CMP: begin
            if (rom_d <= s_q) begin
               r_new[b_q] = 1'b1;
            end
            r_d      = r_new;
            rom_ce_d = 1'b1;
            if (b_q == 3'd0) begin
               rom_a_d = r_new;
               state_d = LO_RD;
            end else begin
               b_d     = b_q - 3'd1;
               rom_a_d = r_new | (7'd1 << (b_q - 3'd1));
               state_d = SAR_RD;
            end
         end
         LO_RD: begin
            state_d = LO_CMP;
         end
         LO_CMP: begin
`ifdef STEP_TO_NOTE_ROUND_EN
            tlo_d      = rom_d;
            lo_exact_d = lo_exact;
            lo_under_d = lo_under;
            if ((r_q != 7'd127) && !lo_under) begin
               rom_ce_d = 1'b1;
               rom_a_d  = r_q + 7'd1;
               state_d  = HI_RD;
            end else begin
               note_d  = r_q;
               exact_d = lo_exact;
               under_d = lo_under;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
`else
            note_d  = r_q;
            exact_d = lo_exact;
            under_d = lo_under;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
`endif
         end
`ifdef STEP_TO_NOTE_ROUND_EN
         HI_RD: begin
            state_d = HI_CMP;
         end
         HI_CMP: begin
            // Strictly closer upper neighbour wins; a tie keeps the lower note.
            r_d     = r_fin;
            note_d  = r_fin;
            exact_d = lo_exact_q;
            under_d = lo_under_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end
`endif
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any conversion without a done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s_q        <= 16'd0;
         r_q        <= 7'd0;
         b_q        <= 3'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         note_q     <= 7'd0;
         exact_q    <= 1'b0;
         under_q    <= 1'b0;
         rom_ce_q   <= 1'b0;
         rom_a_q    <= 7'd0;
`ifdef STEP_TO_NOTE_ROUND_EN
         tlo_q      <= 16'd0;
         lo_exact_q <= 1'b0;
         lo_under_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         r_q        <= r_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         note_q     <= note_d;
         exact_q    <= exact_d;
         under_q    <= under_d;
         rom_ce_q   <= rom_ce_d;
         rom_a_q    <= rom_a_d;
`ifdef STEP_TO_NOTE_ROUND_EN
         tlo_q      <= tlo_d;
         lo_exact_q <= lo_exact_d;
         lo_under_q <= lo_under_d;
`endif
      end
   end

endmodule

// File: tb/tb_step_to_note.sv
// Testbench for step_to_note: registered table ROM, linear-scan reference
// model of the nearest-note rule, directed and random conversions, restart
// and reset-abort scenarios.
module tb_step_to_note;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] step;
   logic        busy;
   logic        done;
   logic [6:0]  note;
   logic        exact;
   logic        under;
   logic        rom_ce;
   logic [6:0]  rom_a;
   logic [15:0] rom_d = 16'd0;

   int checks = 0;
   int errors = 0;
   int rom_reads = 0;
   logic [15:0] tbl [128];

   step_to_note dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .step   (step),
      .busy   (busy),
      .done   (done),
      .note   (note),
      .exact  (exact),
      .under  (under),
      .rom_ce (rom_ce),
      .rom_a  (rom_a),
      .rom_d  (rom_d)
   );

   // clock
   always #5 clk = ~clk;

   // registered table ROM
   always @(posedge clk) begin
      if (rom_ce) begin
         rom_d <= tbl[rom_a];
         rom_reads = rom_reads + 1;
      end
   end

   // NCO step table: 440 Hz at note 69, 32 kHz sample rate, 16-bit phase
   task automatic build_table();
      real ratio;
      real f;
      ratio = 1.0594630943592953;
      f = 440.0 * 65536.0 / 32000.0;
      for (int n = 69; n < 128; n++) begin
         tbl[n] = 16'($rtoi(f + 0.5));
         f = f * ratio;
      end
      f = (440.0 * 65536.0 / 32000.0) / ratio;
      for (int n = 68; n >= 0; n--) begin
         tbl[n] = 16'($rtoi(f + 0.5));
         f = f / ratio;
      end
   endtask

   // reference model: nearest table entry by direct scan and distances
   task automatic model(input logic [15:0] s, output logic [6:0] n,
                        output logic ex, output logic un,
                        output int lat, output int reads);
      int idx;
      idx = -1;
      for (int i = 0; i < 128; i++) begin
         if (tbl[i] <= s) idx = i;
      end
      lat = 16;
      reads = 8;
      if (idx < 0) begin
         n = 7'd0;
         un = 1'b1;
         ex = 1'b0;
      end else begin
         n = 7'(idx);
         un = 1'b0;
         ex = (tbl[idx] == s);
`ifdef STEP_TO_NOTE_ROUND_EN
         if (idx < 127) begin
            lat = 18;
            reads = 9;
            if ((int'(tbl[idx+1]) - int'(s)) < (int'(s) - int'(tbl[idx])))
               n = 7'(idx + 1);
         end
`endif
      end
   endtask

   // driver: one conversion, returns observed results and protocol health
   task automatic do_conv(input logic [15:0] s, output int lat,
                          output logic [6:0] n, output logic ex,
                          output logic un, output int reads,
                          output bit proto_ok);
      int r0;
      logic [6:0] n0;
      logic e0, u0;
      proto_ok = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      step = s;
      n0 = note; e0 = exact; u0 = under;
      r0 = rom_reads;
      @(posedge clk); #1;
      start = 1'b0;
      step = 16'($urandom);
      if (busy !== 1'b1) proto_ok = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) proto_ok = 1'b0;
         if (note !== n0 || exact !== e0 || under !== u0) proto_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (done !== 1'b1) lat = -1;
      if (busy !== 1'b0) proto_ok = 1'b0;
      n = note; ex = exact; un = under;
      reads = rom_reads - r0;
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) proto_ok = 1'b0;
      if (note !== n || exact !== ex || under !== un) proto_ok = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, note, exact, under, rom_ce, rom_a} !== 19'd0) begin
         errors++;
         $display("FAIL reset_in: got busy=%b done=%b note=%0d exact=%b under=%b rom_ce=%b rom_a=%0d want all 0",
                  busy, done, note, exact, under, rom_ce, rom_a);
      end
      #20 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, note, exact, under, rom_ce, rom_a} !== 19'd0) begin
         errors++;
         $display("FAIL reset_out: got busy=%b done=%b note=%0d exact=%b under=%b rom_ce=%b rom_a=%0d want all 0",
                  busy, done, note, exact, under, rom_ce, rom_a);
      end
   endtask

   task automatic test_directed();
      logic [15:0] vec [5];
      logic [6:0] n, en;
      logic ex, un, eex, eun;
      int lat, elat, rd, erd;
      bit ok;
      vec[0] = 16'd901; vec[1] = 16'd880; vec[2] = 16'd876;
      vec[3] = 16'd5;   vec[4] = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         model(vec[i], en, eex, eun, elat, erd);
         do_conv(vec[i], lat, n, ex, un, rd, ok);
         checks++;
         if (n !== en || ex !== eex || un !== eun) begin
            errors++;
            $display("FAIL directed_result step=%0d: got note=%0d exact=%b under=%b want note=%0d exact=%b under=%b",
                     vec[i], n, ex, un, en, eex, eun);
         end
         checks++;
         if (lat !== elat) begin
            errors++;
            $display("FAIL directed_latency step=%0d: got %0d want %0d", vec[i], lat, elat);
         end
         checks++;
         if (rd !== erd || !ok) begin
            errors++;
            $display("FAIL directed_protocol step=%0d: got reads=%0d ok=%0d want reads=%0d ok=1",
                     vec[i], rd, ok, erd);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] s;
      logic [6:0] n, en;
      logic ex, un, eex, eun;
      int lat, elat, rd, erd, idx, v;
      bit ok;
      for (int k = 0; k < 40; k++) begin
         idx = $urandom_range(0, 126);
         case ($urandom_range(0, 3))
            0: v = tbl[idx];
            1: v = int'(tbl[idx]) + $urandom_range(0, 4) - 2;
            2: v = (int'(tbl[idx]) + int'(tbl[idx+1])) / 2;
            default: v = $urandom_range(0, 65535);
         endcase
         if (v < 0) v = 0;
         s = 16'(v);
         model(s, en, eex, eun, elat, erd);
         do_conv(s, lat, n, ex, un, rd, ok);
         checks++;
         if (n !== en || ex !== eex || un !== eun || lat !== elat || rd !== erd || !ok) begin
            errors++;
            $display("FAIL random step=%0d: got note=%0d exact=%b under=%b lat=%0d reads=%0d ok=%0d want note=%0d exact=%b under=%b lat=%0d reads=%0d",
                     s, n, ex, un, lat, rd, ok, en, eex, eun, elat, erd);
         end
      end
   endtask

   task automatic test_ignore_restart();
      logic [6:0] en;
      logic eex, eun;
      int elat, erd, dones, first;
      logic [6:0] got_n;
      model(16'd901, en, eex, eun, elat, erd);
      @(posedge clk); #1;
      start = 1'b1; step = 16'd901;
      @(posedge clk); #1;
      start = 1'b0;
      dones = 0; first = -1; got_n = 7'd0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 4) begin start = 1'b1; step = 16'd17; end
         if (c == 5) start = 1'b0;
         @(posedge clk); #1;
         if (done === 1'b1) begin
            dones++;
            if (first < 0) begin first = c; got_n = note; end
         end
      end
      checks++;
      if (dones !== 1) begin
         errors++;
         $display("FAIL restart_done_count: got %0d want 1", dones);
      end
      checks++;
      if (got_n !== en || first !== elat) begin
         errors++;
         $display("FAIL restart_result: got note=%0d lat=%0d want note=%0d lat=%0d", got_n, first, en, elat);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] en1, en2;
      logic eex, eun;
      int elat1, elat2, erd, cnt;
      logic [15:0] s1, s2;
      s1 = tbl[$urandom_range(10, 120)];
      s2 = 16'($urandom_range(100, 20000));
      model(s1, en1, eex, eun, elat1, erd);
      model(s2, en2, eex, eun, elat2, erd);
      @(posedge clk); #1;
      start = 1'b1; step = s1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      while (done !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (cnt !== elat1 || note !== en1) begin
         errors++;
         $display("FAIL b2b_first: got lat=%0d note=%0d want lat=%0d note=%0d", cnt, note, elat1, en1);
      end
      start = 1'b1; step = s2;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done_cycle_start: got busy=%b done=%b want busy=0 done=0", busy, done);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b want 1", busy);
      end
      cnt = 0;
      while (done !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (cnt !== elat2 || note !== en2) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d note=%0d want lat=%0d note=%0d", cnt, note, elat2, en2);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] n, en;
      logic ex, un, eex, eun;
      int lat, elat, rd, erd, dones;
      bit ok;
      logic [15:0] s;
      @(posedge clk); #1;
      start = 1'b1; step = 16'd901;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, note, exact, under, rom_ce, rom_a} !== 19'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got busy=%b done=%b note=%0d exact=%b under=%b rom_ce=%b rom_a=%0d want all 0",
                  busy, done, note, exact, under, rom_ce, rom_a);
      end
      dones = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0 || rom_ce !== 1'b0) dones++;
      end
      #2 rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL midreset_quiet: got %0d active cycles want 0", dones);
      end
      s = 16'd880;
      model(s, en, eex, eun, elat, erd);
      do_conv(s, lat, n, ex, un, rd, ok);
      checks++;
      if (n !== en || ex !== eex || un !== eun || lat !== elat || !ok) begin
         errors++;
         $display("FAIL midreset_fresh: got note=%0d exact=%b under=%b lat=%0d ok=%0d want note=%0d exact=%b under=%b lat=%0d",
                  n, ex, un, lat, ok, en, eex, eun, elat);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      step  = 16'd0;
      build_table();
      #12;
      test_reset();
      test_directed();
      test_random();
      test_ignore_restart();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/step_to_note.md
# step_to_note

Inverse pitch lookup: converts a 16-bit NCO phase step size back to the nearest MIDI note number (0..127). Performs a 7-step successive-approximation search over the NCO step-size table (128 × 16-bit entries, monotonically increasing, registered read) through an external ROM read port. Sits beside the NCO in the pitch path, for pitch-bend/glide display, tuning readback and note tracking of modulated oscillators.

## Interface
- No parameters (table depth 128, step width 16 fixed by the NCO).
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- step  in  16  step size to convert; latched on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse, result valid
- note  out  7  resulting note number; holds until next done
- exact  out  1  step equals table[note]
- under  out  1  step < table[0]
- rom_ce  out  1  table read enable
- rom_a  out  7  table address
- rom_d  in  16  table data, valid the cycle after rom_ce/rom_a

## Operation
- States: IDLE, SAR_RD, SAR_CMP, LO_RD, LO_CMP, HI_RD, HI_CMP, DONE.
- IDLE: start=1 → latch step into s, clear r (7-bit result) and bit index b=6 → SAR_RD. start while busy is ignored.
- SAR_RD: rom_ce=1, rom_a = r | (1<<b) → SAR_CMP.
- SAR_CMP: if rom_d <= s, r[b]=1. If b==0 → LO_RD, else b-=1 → SAR_RD.
- After 7 iterations r = largest i with table[i] <= s, or 0 if none.
- LO_RD: rom_ce=1, rom_a=r → LO_CMP. LO_CMP: store tlo=rom_d; under = (s < tlo); exact = (s == tlo). Next: HI_RD if rounding compiled in, r!=127 and under==0; else DONE.
- HI_RD: rom_ce=1, rom_a=r+1 → HI_CMP. HI_CMP: dlo = s − tlo, dhi = rom_d − s (16-bit unsigned, both non-negative by construction); if dhi < dlo then r=r+1 → DONE. Ties keep lower note.
- DONE: note=r, exact/under registered, done=1 for one cycle, busy=0 → IDLE.
- rom_ce=0 and rom_a holds last value in all other states.
- s=0xFFFF: r=127, exact=0. s < table[0]: note=0, under=1, exact=0.

## Timing
- Reset values: busy=0, done=0, note=0, exact=0, under=0, rom_ce=0, rom_a=0; state IDLE.
- Reset asserted mid-conversion: abort immediately, all outputs to reset values, no done pulse.
- Start accepted at edge k: busy=1 after edge k; each table access costs 2 cycles (RD, CMP).
- Latency (edge k to edge where done rises): 18 cycles with HI read; 16 cycles without (rounding disabled, r==127, or under).
- done and busy never both high; start in the DONE cycle is ignored; next start accepted in IDLE the following cycle.
- Outputs note/exact/under change only on the edge that raises done.

## Configuration
- STEP_TO_NOTE_ROUND_EN defined: nearest-note rounding via HI_RD/HI_CMP, ties to lower note.
- Undefined: HI states not built; note = floor index (largest table[i] <= step); latency always 16.

## Test plan
- step=901 → note=69, exact=1, under=0; done 18 cycles after start (16 without rounding).
- step=880 (table[68]=851, table[69]=901) → note=69, exact=0 with rounding; note=68 without.
- step=876 (dlo=dhi=25) → note=68 (tie to lower), exact=0.
- step=5 → note=0, under=1, exact=0, latency 16; step=65535 → note=127, exact=0, latency 16.
- start re-pulsed with step=17 during busy → ignored, first result delivered unchanged; exactly one done.
- rst_n low at cycle 7 of a conversion → all outputs reset immediately, rom_ce=0, no done; fresh start afterwards converts normally.
